calaadd: RTL and testbench



---
 rtl/calaadd.sv | 105 ++++++++++
 tb/tb_calaadd.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/calaadd.sv
// Registered carry-lookahead adder: 4-bit lookahead blocks joined by a second-level
// lookahead unit, with group generate/propagate for use in wider lookahead trees.
module calaadd #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             g,
    output logic             p,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int NB = WIDTH / 4;

    logic [WIDTH-1:0] bit_p;
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_c;
    logic [NB-1:0]    blk_g;
    logic [NB-1:0]    blk_p;
    logic [NB:0]      blk_c;
    logic             grp_g;
    logic             grp_p;

    logic             g_q,  g_d;
    logic             p_q,  p_d;
    logic [WIDTH-1:0] s_q,  s_d;
    logic             co_q, co_d;

    // AND of v[lo..hi-1]; an empty range is the identity 1.
    function automatic logic and_range(input logic [NB-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int m = 0; m < NB; m++) begin
            if (m >= lo && m < hi) r = r & v[m];
        end
        return r;
    endfunction

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [3:0] lp;
        logic [3:0] lg;
        logic       c0;
        assign lp = bit_p[4*k +: 4];
        assign lg = bit_g[4*k +: 4];
        assign c0 = blk_c[k];

        assign bit_c[4*k]   = c0;
        assign bit_c[4*k+1] = lg[0] | (lp[0] & c0);
        assign bit_c[4*k+2] = lg[1] | (lp[1] & lg[0]) | (lp[1] & lp[0] & c0);
        assign bit_c[4*k+3] = lg[2] | (lp[2] & lg[1]) | (lp[2] & lp[1] & lg[0])
                            | (lp[2] & lp[1] & lp[0] & c0);

        assign blk_g[k] = lg[3] | (lp[3] & lg[2]) | (lp[3] & lp[2] & lg[1])
                        | (lp[3] & lp[2] & lp[1] & lg[0]);
        assign blk_p[k] = &lp;
    end

    // Second level: every block carry-in is a flat sum of products of lower BG/BP and ci.
    always_comb begin
        blk_c = '0;
        grp_g = 1'b0;
        for (int k = 0; k <= NB; k++) begin
            blk_c[k] = ci & and_range(blk_p, 0, k);
            for (int j = 0; j < NB; j++) begin
                if (j < k) blk_c[k] = blk_c[k] | (blk_g[j] & and_range(blk_p, j + 1, k));
            end
        end
        for (int j = 0; j < NB; j++) begin
            grp_g = grp_g | (blk_g[j] & and_range(blk_p, j + 1, NB));
        end
        grp_p = &blk_p;
    end

    always_comb begin
        g_d  = grp_g;
        p_d  = grp_p;
        s_d  = bit_p ^ bit_c;
        co_d = blk_c[NB];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q  <= 1'b0;
            p_q  <= 1'b0;
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            g_q  <= g_d;
            p_q  <= p_d;
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign g  = g_q;
    assign p  = p_q;
    assign s  = s_q;
    assign co = co_q;
endmodule

// File: tb/tb_calaadd.sv
// Scoreboard bench for calaadd: a 4-bit instance (hand vectors + exhaustive sweep)
// and a 32-bit instance (boundary and random vectors) driven in lockstep.
module tb_calaadd;
    logic clk;
    logic rst_n;

    logic [3:0]  a4, b4, s4;
    logic        ci4, g4, p4, co4;
    logic [31:0] a32, b32, s32;
    logic        ci32, g32, p32, co32;

    // Expected word layout: {g, p, co, s}
    logic [6:0]  exp4_q[$];
    logic [34:0] exp32_q[$];

    int n_cmp;
    int n_fail;

    calaadd #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .ci(ci4),
        .g(g4), .p(p4), .s(s4), .co(co4)
    );

    calaadd #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .ci(ci32),
        .g(g32), .p(p32), .s(s32), .co(co32)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, written from the arithmetic definition only.
    function automatic logic [6:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] sum;
        logic [4:0] gen;
        sum = {1'b0, x} + {1'b0, y} + {4'b0, c};
        gen = {1'b0, x} + {1'b0, y};
        return {gen[4], &(x ^ y), sum[4], sum[3:0]};
    endfunction

    function automatic logic [34:0] model32(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] sum;
        logic [32:0] gen;
        sum = {1'b0, x} + {1'b0, y} + {32'b0, c};
        gen = {1'b0, x} + {1'b0, y};
        return {gen[32], &(x ^ y), sum[32], sum[31:0]};
    endfunction

    function automatic void check(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Driver tasks: inputs change on the falling edge; expected result is queued
    // for the rising edge that follows.
    task automatic drive_dir(input logic [3:0] x, input logic [3:0] y, input logic c,
                             input logic [6:0] exp4, input logic [31:0] x32,
                             input logic [31:0] y32, input logic c32);
        @(negedge clk);
        a4 = x; b4 = y; ci4 = c;
        a32 = x32; b32 = y32; ci32 = c32;
        exp4_q.push_back(exp4);
        exp32_q.push_back(model32(x32, y32, c32));
    endtask

    task automatic drive_model(input logic [3:0] x, input logic [3:0] y, input logic c,
                               input logic [31:0] x32, input logic [31:0] y32, input logic c32);
        drive_dir(x, y, c, model4(x, y, c), x32, y32, c32);
    endtask

    task automatic check_zero(input string name);
        check({name, "_w4"},  {28'b0, g4, p4, co4, s4}, 35'b0);
        check({name, "_w32"}, {g32, p32, co32, s32},    35'b0);
    endtask

    // Monitor: one result per rising edge while out of reset.
    always @(posedge clk) begin
        if (rst_n && exp4_q.size() > 0) begin
            logic [6:0]  e4;
            logic [34:0] e32;
            #1;
            e4  = exp4_q.pop_front();
            check("sum_w4", {28'b0, g4, p4, co4, s4}, {28'b0, e4});
            check("inv_w4", {34'b0, co4}, {34'b0, g4 | (p4 & e4[4])});
            if (exp32_q.size() > 0) begin
                e32 = exp32_q.pop_front();
                check("sum_w32", {g32, p32, co32, s32}, e32);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        a4 = 4'b1111; b4 = 4'b1111; ci4 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; ci32 = 1'b1;

        #3 check_zero("reset_init");
        repeat (2) @(posedge clk);
        #2 check_zero("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed directed vectors
        drive_dir(4'b0001, 4'b0011, 1'b0, 7'b000_0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drive_dir(4'b0001, 4'b0011, 1'b1, 7'b000_0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive_dir(4'b0101, 4'b1010, 1'b0, 7'b010_1111, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0);
        drive_dir(4'b0101, 4'b1010, 1'b1, 7'b011_0000, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
        drive_dir(4'b1111, 4'b1111, 1'b0, 7'b101_1110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        drive_dir(4'b1111, 4'b1111, 1'b1, 7'b101_1111, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Exhaustive 4-bit sweep; 32-bit gets random operands every cycle
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            drive_model(v[3:0], v[7:4], v[8], $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        // Mid-stream asynchronous reset, once the pipeline has drained
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk);
        #1 check_zero("reset_mid_hold");

        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'b0111; b4 = 4'b0001; ci4 = 1'b0;
        a32 = 32'h0000_FFFF; b32 = 32'h0000_0001; ci32 = 1'b0;
        exp4_q.push_back(7'b000_1000);
        exp32_q.push_back(model32(32'h0000_FFFF, 32'h0000_0001, 1'b0));

        for (int i = 0; i < 200; i++) begin
            drive_model(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                        $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #3;
        check("drain_w4",  35'(exp4_q.size()),  35'd0);
        check("drain_w32", 35'(exp32_q.size()), 35'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
